// File: rtl/mem_pkg.sv
// Shared encodings for the mem_port load/store front end: access sizes,
// FSM states and byte-lane masks.
package mem_pkg;

  localparam logic [1:0] SIZE_B   = 2'd0;
  localparam logic [1:0] SIZE_H   = 2'd1;
  localparam logic [1:0] SIZE_W   = 2'd2;
  localparam logic [1:0] SIZE_ILL = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [3:0] LANE_NONE = 4'b0000;
  localparam logic [3:0] LANE_B0   = 4'b0001;
  localparam logic [3:0] LANE_H0   = 4'b0011;
  localparam logic [3:0] LANE_H1   = 4'b1100;
  localparam logic [3:0] LANE_W    = 4'b1111;

endpackage

// File: rtl/mem_port_if.sv
// Core-side request/response bundle of mem_port; the core is the master,
// mem_port the slave.
interface mem_port_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_align.sv
// Combinational lane logic: store mask/data replication, load extraction and
// extension, request legality. MEM_ALIGN_CHECK_EN makes misaligned half/word illegal.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  req_size_i,
  input  logic [1:0]  req_off_i,
  input  logic [31:0] req_wdata_i,
  output logic [3:0]  st_we_o,
  output logic [31:0] st_din_o,
  output logic        legal_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_dout_i,
  output logic [31:0] ld_rdata_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    st_we_o  = LANE_NONE;
    st_din_o = req_wdata_i;
    case (req_size_i)
      SIZE_B: begin
        st_we_o  = LANE_B0 << req_off_i;
        st_din_o = {4{req_wdata_i[7:0]}};
      end
      SIZE_H: begin
        st_we_o  = req_off_i[1] ? LANE_H1 : LANE_H0;
        st_din_o = {2{req_wdata_i[15:0]}};
      end
      SIZE_W:  st_we_o = LANE_W;
      default: st_we_o = LANE_NONE;
    endcase
  end

  always_comb begin
    legal_o = (req_size_i != SIZE_ILL);
`ifdef MEM_ALIGN_CHECK_EN
    if (req_size_i == SIZE_H && req_off_i[0])
      legal_o = 1'b0;
    if (req_size_i == SIZE_W && req_off_i != 2'd0)
      legal_o = 1'b0;
`endif
  end

  // Half loads only look at offset bit 1, which also forces alignment when unchecked.
  always_comb begin
    byteSel    = ld_dout_i[{ld_off_i, 3'b000} +: 8];
    halfSel    = ld_dout_i[{ld_off_i[1], 4'b0000} +: 16];
    ld_rdata_o = ld_dout_i;
    case (ld_size_i)
      SIZE_B:  ld_rdata_o = {{24{~ld_unsigned_i & byteSel[7]}}, byteSel};
      SIZE_H:  ld_rdata_o = {{16{~ld_unsigned_i & halfSel[15]}}, halfSel};
      default: ld_rdata_o = ld_dout_i;
    endcase
  end

endmodule

// File: rtl/mem_port.sv
// Byte-addressed load/store front end for a word-organised 1-cycle-read ram.
// Optional MEM_ALIGN_CHECK_EN (in mem_align) rejects misaligned half/word accesses.
module mem_port
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_if.slave             core,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  output logic                  ram_re,
  output logic [3:0]            ram_we,
  input  logic [31:0]           ram_dout
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           din_q, din_d;
  logic [3:0]            we_q, we_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic                  unsigned_q, unsigned_d;
  logic                  err_q, err_d;

  logic [3:0]  alignWe;
  logic [31:0] alignDin;
  logic        alignLegal;
  logic [31:0] ldRdata;

  logic        reqReady;
  logic        respValid;
  logic        respErr;
  logic [31:0] respRdata;
  logic        ramRe;
  logic [3:0]  ramWe;

  // Address bits above the ram window are dropped, so the address space aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^core.req_addr[31:ADDR_WIDTH+2];

  mem_align u_align (
    .req_size_i    (core.req_size),
    .req_off_i     (core.req_addr[1:0]),
    .req_wdata_i   (core.req_wdata),
    .st_we_o       (alignWe),
    .st_din_o      (alignDin),
    .legal_o       (alignLegal),
    .ld_size_i     (size_q),
    .ld_off_i      (off_q),
    .ld_unsigned_i (unsigned_q),
    .ld_dout_i     (ram_dout),
    .ld_rdata_o    (ldRdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      din_q      <= '0;
      we_q       <= LANE_NONE;
      write_q    <= 1'b0;
      size_q     <= SIZE_B;
      off_q      <= 2'd0;
      unsigned_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      we_q       <= we_d;
      write_q    <= write_d;
      size_q     <= size_d;
      off_q      <= off_d;
      unsigned_q <= unsigned_d;
      err_q      <= err_d;
    end
  end

  // Illegal requests skip ACCESS so the ram is never touched for them.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    din_d      = din_q;
    we_d       = we_q;
    write_d    = write_q;
    size_d     = size_q;
    off_d      = off_q;
    unsigned_d = unsigned_q;
    err_d      = err_q;
    reqReady   = 1'b0;
    respValid  = 1'b0;
    respErr    = 1'b0;
    respRdata  = '0;
    ramRe      = 1'b0;
    ramWe      = LANE_NONE;
    case (state_q)
      IDLE: begin
        reqReady = 1'b1;
        if (core.req_valid) begin
          write_d = core.req_write;
          err_d   = ~alignLegal;
          if (alignLegal) begin
            addr_d     = core.req_addr[ADDR_WIDTH+1:2];
            din_d      = alignDin;
            we_d       = alignWe;
            size_d     = core.req_size;
            off_d      = core.req_addr[1:0];
            unsigned_d = core.req_unsigned;
            state_d    = ACCESS;
          end else begin
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        ramRe   = ~write_q;
        ramWe   = write_q ? we_q : LANE_NONE;
        state_d = RESP;
      end
      RESP: begin
        respValid = 1'b1;
        respErr   = err_q;
        respRdata = (write_q || err_q) ? '0 : ldRdata;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign core.req_ready  = reqReady;
  assign core.resp_valid = respValid;
  assign core.resp_err   = respErr;
  assign core.resp_rdata = respRdata;
  assign ram_addr        = addr_q;
  assign ram_din         = din_q;
  assign ram_re          = ramRe;
  assign ram_we          = ramWe;

endmodule

// File: doc/mem_port.md
Name: mem_port

Overview:
- Load/store front end that sits directly upstream of the word-organised `ram` block (11-bit word address, 32-bit data, `re`, 4-bit byte `we`, 1-cycle synchronous read).
- Accepts byte/halfword/word requests from the core on a byte address.
- Converts each request into word address, byte-lane write enables and replicated write data.
- For loads, extracts the addressed lane from `ram` dout and sign- or zero-extends it.
- Returns one response per request.

Parameters:
- ADDR_WIDTH, 11, word-address width of the attached ram (depth = 2**ADDR_WIDTH words).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  load zero-extends when 1; ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  request rejected, no ram access made.
- ram_addr  out  ADDR_WIDTH  to ram addr.
- ram_din  out  32  to ram din.
- ram_re  out  1  to ram re.
- ram_we  out  4  to ram we.
- ram_dout  in  32  from ram dout.

Behaviour:
- Reset is synchronous, active-high, single clock `clk`. After the reset edge:
  - state = IDLE, req_ready = 1.
  - resp_valid, resp_err, ram_re = 0; ram_we = 0.
  - resp_rdata, ram_addr, ram_din = 0.
- FSM states IDLE, ACCESS, RESP.
  - req_ready = 1 only in IDLE.
  - Handshake is req_valid && req_ready.
  - No backpressure on the response.
- Handshake in cycle N (IDLE), legal request:
  - Register ram_addr = req_addr[ADDR_WIDTH+1:2]; upper address bits are ignored, so the address aliases.
  - Register lane enables and data; go to ACCESS.
- ACCESS (cycle N+1):
  - Load: ram_re = 1, ram_we = 0.
  - Store: ram_re = 0, ram_we = lane mask.
  - Go to RESP.
  - ram_re and ram_we are high for exactly this one cycle.
- RESP (cycle N+2):
  - ram_re = ram_we = 0; resp_valid = 1.
  - Load: resp_rdata = extracted ram_dout.
  - Go to IDLE.
  - Fixed latency: handshake to resp_valid = 2 cycles. Throughput: 1 request per 3 cycles.
- Illegal request (req_size = 3, or misaligned with the macro defined):
  - Handshake moves straight to RESP; ACCESS is skipped.
  - resp_valid = 1, resp_err = 1, resp_rdata = 0.
  - ram_re and ram_we stay 0 throughout.
- Store lanes (b = req_addr[1:0]):
  - byte: we = 4'b0001 << b, din = {4{wdata[7:0]}}.
  - half: we = b[1] ? 4'b1100 : 4'b0011, din = {2{wdata[15:0]}}.
  - word: we = 4'b1111, din = wdata.
- Load extraction: shift ram_dout right by 8*b (half uses b[1] only), then:
  - byte: extend bit 7.
  - half: extend bit 15.
  - word: pass through.
  - Unsigned loads zero-extend.
- req_valid is ignored outside IDLE.
- Reset asserted in ACCESS or RESP: next cycle is IDLE with all outputs at reset values. Any write in progress is dropped unless the ram already sampled it.

Optional Feature:
- MEM_ALIGN_CHECK_EN
- Defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, is illegal → resp_err path, no ram access.
- Undefined:
  - Alignment is forced: half ignores addr[0], word ignores addr[1:0].
  - The access proceeds normally with resp_err = 0.
  - Only size 3 errors.

Decomposition:
- Shared package mem_pkg:
  - size encodings SIZE_B = 0, SIZE_H = 1, SIZE_W = 2.
  - FSM state enum.
  - Lane-mask constants.
- One combinational sub-module mem_align:
  - store lane mask and data replication.
  - load extraction and extension.
  - legality check.
- FSM and registers stay in mem_port.

Test Plan:
- Reset → req_ready = 1; ram_re, ram_we and resp_valid = 0.
- Store word addr 0x8, wdata 0xDEADBEEF:
  - ACCESS: ram_addr = 2, ram_we = 4'b1111.
  - resp_valid at N+2, resp_err = 0.
- Store byte 0xAA at addr 0x9 → ram_we = 4'b0010, ram_din = 0xAAAAAAAA. Then load signed byte at addr 0x9 → resp_rdata = 0xFFFFFFAA; load unsigned → 0x000000AA.
- Load signed half at addr 0xA over word 0x8001_1234 → resp_rdata = 0xFFFF8001. ram_re is high exactly 1 cycle.
- Size-3 request → resp_err = 1 at N+1, no ram_re or ram_we. With MEM_ALIGN_CHECK_EN, word load at addr 0x6 → resp_err = 1; without it, reads word 1.
- Reset asserted during ACCESS of a load → no resp_valid, IDLE and req_ready = 1 next cycle.
